// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read channel between the fetch stage and memory.
//   imem_req   fetch -> mem  read request
//   imem_addr  fetch -> mem  word address (equals PC)
//   imem_data  mem -> fetch  instruction, valid when imem_ready=1
//   imem_ready mem -> fetch  read-complete strobe, meaningful only while imem_req=1
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ready;
  modport master (output imem_req, output imem_addr, input imem_data, input imem_ready);
  modport slave (input imem_req, input imem_addr, output imem_data, output imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory request FSM with one-word skid buffer, and IF/ID register.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   stall        hold PC and IF/ID
//   kill         flush IF/ID and redirect PC (beats stall)
//   PcSrc        redirect select: 0 current PC, 1 JumpTarget, 2 BranchTarget, 3 ReturnAddr
//   JumpTarget, BranchTarget, ReturnAddr  redirect addresses
//   imem         instruction-memory channel (master side)
//   IFID_Instr, IFID_PC, IFID_NPC, IFID_Valid  IF/ID register contents
//   opCode       IFID_Instr[15:12]
//   InstrCount   instructions delivered into IF/ID, wraps
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                kill,
  input  logic [1:0]          PcSrc,
  input  logic [15:0]         JumpTarget,
  input  logic [15:0]         BranchTarget,
  input  logic [15:0]         ReturnAddr,
  fetch_stage_if.master       imem,
  output logic [15:0]         IFID_Instr,
  output logic [15:0]         IFID_PC,
  output logic [15:0]         IFID_NPC,
  output logic                IFID_Valid,
  output logic [3:0]          opCode,
  output logic [15:0]         InstrCount
);
  typedef enum logic {S_REQ, S_BUF} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifid_pc_q, ifid_pc_d;
  logic [15:0] ifid_npc_q, ifid_npc_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pc_inc;
  logic [15:0] redirect;
  assign pc_inc = pc_q + 16'd1;
  assign redirect = PcSrc == 2'd0 ? pc_q :
                    PcSrc == 2'd1 ? JumpTarget :
                    PcSrc == 2'd2 ? BranchTarget : ReturnAddr;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_npc_d = ifid_npc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    if (kill) begin
      // Any word returning this cycle belongs to the squashed path and is dropped.
      pc_d    = redirect;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      buf_d   = '0;
      state_d = S_REQ;
    end else if (state_q == S_REQ) begin
      if (imem.imem_ready && !stall) begin
        instr_d    = imem.imem_data;
        ifid_pc_d  = pc_q;
        ifid_npc_d = pc_inc;
        valid_d    = 1'b1;
        pc_d       = pc_inc;
        cnt_d      = cnt_q + 16'd1;
      end else if (imem.imem_ready) begin
        // Word arrived while decode is stalled: park it so it is not lost.
        buf_d   = imem.imem_data;
        state_d = S_BUF;
      end else if (!stall) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end else if (!stall) begin
      instr_d    = buf_q;
      ifid_pc_d  = pc_q;
      ifid_npc_d = pc_inc;
      valid_d    = 1'b1;
      pc_d       = pc_inc;
      cnt_d      = cnt_q + 16'd1;
      state_d    = S_REQ;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      ifid_pc_q  <= '0;
      ifid_npc_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_npc_q <= ifid_npc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
    end
  end
  assign imem.imem_req  = state_q == S_REQ;
  assign imem.imem_addr = pc_q;
  assign IFID_Instr     = instr_q;
  assign IFID_PC        = ifid_pc_q;
  assign IFID_NPC       = ifid_npc_q;
  assign IFID_Valid     = valid_q;
  assign opCode         = instr_q[15:12];
  assign InstrCount     = cnt_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  PcSrc = 2'd0;
  logic [15:0] JumpTarget = '0;
  logic [15:0] BranchTarget = '0;
  logic [15:0] ReturnAddr = '0;
  logic [15:0] IFID_Instr, IFID_PC, IFID_NPC, InstrCount;
  logic        IFID_Valid;
  logic [3:0]  opCode;
  logic        use_auto = 1'b0;
  logic [15:0] data_v = '0;
  int          errors = 0;
  int          checks = 0;
  fetch_stage_if bus ();
  assign bus.imem_data = use_auto ? bus.imem_addr + 16'h1000 : data_v;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .kill(kill), .PcSrc(PcSrc),
    .JumpTarget(JumpTarget), .BranchTarget(BranchTarget), .ReturnAddr(ReturnAddr),
    .imem(bus.master), .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC), .IFID_NPC(IFID_NPC),
    .IFID_Valid(IFID_Valid), .opCode(opCode), .InstrCount(InstrCount)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.imem_ready = 1'b0;
    #3;
    check("rst_instr", IFID_Instr, 16'h0000);
    check("rst_valid", {15'd0, IFID_Valid}, 16'd0);
    check("rst_pc", IFID_PC, 16'h0000);
    check("rst_npc", IFID_NPC, 16'h0000);
    check("rst_cnt", InstrCount, 16'd0);
    check("rst_addr", bus.imem_addr, 16'h0000);
    check("rst_req", {15'd0, bus.imem_req}, 16'd1);
    step();
    reset = 1'b1;
    use_auto = 1'b1;
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("seq_instr", IFID_Instr, 16'h1000 + 16'(i));
      check("seq_pc", IFID_PC, 16'(i));
      check("seq_npc", IFID_NPC, 16'(i + 1));
      check("seq_valid", {15'd0, IFID_Valid}, 16'd1);
    end
    check("seq_cnt", InstrCount, 16'd3);
    check("seq_addr", bus.imem_addr, 16'h0003);
    use_auto = 1'b0;
    data_v = 16'h2005;
    stall = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    check("buf_req", {15'd0, bus.imem_req}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check("stall_instr", IFID_Instr, 16'h1002);
      check("stall_addr", bus.imem_addr, 16'h0003);
      check("stall_cnt", InstrCount, 16'd3);
    end
    stall = 1'b0;
    step();
    check("unst_instr", IFID_Instr, 16'h2005);
    check("unst_pc", IFID_PC, 16'h0003);
    check("unst_addr", bus.imem_addr, 16'h0004);
    check("unst_cnt", InstrCount, 16'd4);
    check("unst_op", {12'd0, opCode}, 16'h0002);
    check("unst_req", {15'd0, bus.imem_req}, 16'd1);
    data_v = 16'h3333;
    bus.imem_ready = 1'b1;
    kill = 1'b1;
    PcSrc = 2'd2;
    BranchTarget = 16'h0040;
    step();
    check("kill_valid", {15'd0, IFID_Valid}, 16'd0);
    check("kill_instr", IFID_Instr, 16'h0000);
    check("kill_addr", bus.imem_addr, 16'h0040);
    check("kill_cnt", InstrCount, 16'd4);
    kill = 1'b0;
    bus.imem_ready = 1'b0;
    step();
    check("bubble_instr", IFID_Instr, 16'h0000);
    check("bubble_valid", {15'd0, IFID_Valid}, 16'd0);
    check("bubble_addr", bus.imem_addr, 16'h0040);
    data_v = 16'h4444;
    bus.imem_ready = 1'b1;
    stall = 1'b1;
    step();
    check("buf2_req", {15'd0, bus.imem_req}, 16'd0);
    bus.imem_ready = 1'b0;
    kill = 1'b1;
    PcSrc = 2'd3;
    ReturnAddr = 16'h0123;
    step();
    check("ks_addr", bus.imem_addr, 16'h0123);
    check("ks_valid", {15'd0, IFID_Valid}, 16'd0);
    check("ks_instr", IFID_Instr, 16'h0000);
    check("ks_cnt", InstrCount, 16'd4);
    check("ks_req", {15'd0, bus.imem_req}, 16'd1);
    kill = 1'b0;
    stall = 1'b0;
    step();
    check("ks_drop_instr", IFID_Instr, 16'h0000);
    check("ks_drop_valid", {15'd0, IFID_Valid}, 16'd0);
    kill = 1'b1;
    PcSrc = 2'd1;
    JumpTarget = 16'hFFFF;
    step();
    check("jmp_addr", bus.imem_addr, 16'hFFFF);
    kill = 1'b0;
    data_v = 16'h5555;
    bus.imem_ready = 1'b1;
    step();
    check("wrap_instr", IFID_Instr, 16'h5555);
    check("wrap_pc", IFID_PC, 16'hFFFF);
    check("wrap_npc", IFID_NPC, 16'h0000);
    check("wrap_addr", bus.imem_addr, 16'h0000);
    check("wrap_cnt", InstrCount, 16'd5);
    check("wrap_op", {12'd0, opCode}, 16'h0005);
    data_v = 16'h6666;
    stall = 1'b1;
    step();
    check("buf3_req", {15'd0, bus.imem_req}, 16'd0);
    bus.imem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_addr", bus.imem_addr, 16'h0000);
    check("arst_instr", IFID_Instr, 16'h0000);
    check("arst_valid", {15'd0, IFID_Valid}, 16'd0);
    check("arst_pc", IFID_PC, 16'h0000);
    check("arst_npc", IFID_NPC, 16'h0000);
    check("arst_cnt", InstrCount, 16'd0);
    check("arst_req", {15'd0, bus.imem_req}, 16'd1);
    stall = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("post_instr", IFID_Instr, 16'h0000);
    check("post_valid", {15'd0, IFID_Valid}, 16'd0);
    check("post_cnt", InstrCount, 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
